// File: rtl/fifo_rd_pair_unpacker_if.sv
// Bundle for the pair-read drain stage: the FIFO read side (rempty/rinc/rdata)
// and the single-word valid/ready stream that is handed to the consumer.
interface fifo_rd_pair_unpacker_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  rempty;
    logic                  rinc;
    logic [DATA_WIDTH-1:0] rdata_lo;
    logic [DATA_WIDTH-1:0] rdata_hi;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_first;

    // master: the unpacker itself; slave: FIFO pointer/memory plus consumer
    modport master (
        input  rempty, rdata_lo, rdata_hi, out_ready,
        output rinc, out_data, out_valid, out_first
    );

    modport slave (
        output rempty, rdata_lo, rdata_hi, out_ready,
        input  rinc, out_data, out_valid, out_first
    );
endinterface

// File: rtl/fifo_rd_pair_unpacker.sv
// Read-domain drain stage: pulls two FIFO words per rinc and serialises them
// as a one-word valid/ready stream, with synchronous flush and a word counter.
module fifo_rd_pair_unpacker #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                   rclk,
    input  logic                   rrst_n,
    fifo_rd_pair_unpacker_if.master bus,
    input  logic                   flush,
    output logic [CNT_WIDTH-1:0]   word_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HAVE2 = 2'd1,
        HAVE1 = 2'd2
    } state_t;

    state_t                  state_reg;
    state_t                  state_next;
    logic [DATA_WIDTH-1:0]   buf_lo_reg;
    logic [DATA_WIDTH-1:0]   buf_hi_reg;
    logic [CNT_WIDTH-1:0]    word_cnt_reg;
    logic                    rinc_int;
    logic                    accept;

    // A new pair is fetched either from empty or while the last word of the
    // current pair leaves, so a ready consumer sees no bubble between pairs.
    assign rinc_int = !flush && !bus.rempty &&
                      ((state_reg == IDLE) || ((state_reg == HAVE1) && bus.out_ready));

    assign accept   = (state_reg != IDLE) && bus.out_ready && !flush;
    assign bus.rinc = rinc_int;
    assign word_cnt = word_cnt_reg;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (flush) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (rinc_int) state_next = HAVE2;
                end
                HAVE2: begin
                    if (bus.out_ready) state_next = HAVE1;
                end
                HAVE1: begin
                    if (bus.out_ready) state_next = rinc_int ? HAVE2 : IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        bus.out_valid = 1'b0;
        bus.out_first = 1'b0;
        bus.out_data  = '0;
        case (state_reg)
            HAVE2: begin
                bus.out_valid = 1'b1;
                bus.out_first = 1'b1;
                bus.out_data  = buf_lo_reg;
            end
            HAVE1: begin
                bus.out_valid = 1'b1;
                bus.out_data  = buf_hi_reg;
            end
            default: begin
                bus.out_valid = 1'b0;
            end
        endcase
    end

    // Memory is read asynchronously, so both words are valid on the same edge
    // the pointer logic advances; sampling here takes the pre-advance data.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            buf_lo_reg <= '0;
            buf_hi_reg <= '0;
        end else if (rinc_int) begin
            buf_lo_reg <= bus.rdata_lo;
            buf_hi_reg <= bus.rdata_hi;
        end
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            word_cnt_reg <= '0;
        end else if (accept) begin
            word_cnt_reg <= word_cnt_reg + 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_rd_pair_unpacker.sv
// Scoreboard bench: a queue-based FIFO model feeds the unpacker, and words the
// model expects to be held are compared against each accepted output word.
module tb_fifo_rd_pair_unpacker;

    localparam int DW = 8;
    localparam int CW = 10;

    logic          rclk = 1'b0;
    logic          rrst_n = 1'b0;
    logic          flush = 1'b0;
    logic [CW-1:0] word_cnt;

    fifo_rd_pair_unpacker_if #(.DATA_WIDTH(DW)) bus ();

    fifo_rd_pair_unpacker #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .rclk     (rclk),
        .rrst_n   (rrst_n),
        .bus      (bus),
        .flush    (flush),
        .word_cnt (word_cnt)
    );

    always #5 rclk = ~rclk;

    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] held_q[$];
    logic [CW-1:0] sb_cnt = '0;
    bit            blk_empty = 1'b1;
    int            tests = 0;
    int            fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic refresh();
        bus.rempty   = blk_empty || (fifo_q.size() < 2);
        bus.rdata_lo = (fifo_q.size() > 0) ? fifo_q[0] : '0;
        bus.rdata_hi = (fifo_q.size() > 1) ? fifo_q[1] : '0;
    endtask

    task automatic push_pair(input logic [DW-1:0] lo, input logic [DW-1:0] hi);
        fifo_q.push_back(lo);
        fifo_q.push_back(hi);
    endtask

    // Inputs are applied 1 time unit after the edge and held for one cycle.
    task automatic drive(input bit rdy, input bit fl, input bit blk);
        bus.out_ready = rdy;
        flush         = fl;
        blk_empty     = blk;
        refresh();
        @(posedge rclk);
        #1;
    endtask

    // Monitor: checks at the falling edge, commits model updates at the rising edge.
    initial begin : monitor
        bit            do_acc;
        bit            do_fl;
        bit            do_rinc;
        bit            exp_valid;
        bit            exp_rinc;
        forever begin
            @(negedge rclk);
            do_acc = 1'b0;
            do_fl = 1'b0;
            do_rinc = 1'b0;
            if (!rrst_n) begin
                held_q.delete();
                sb_cnt = '0;
                check("rst_valid", 32'(bus.out_valid), 32'd0);
                check("rst_data", 32'(bus.out_data), 32'd0);
                check("rst_cnt", 32'(word_cnt), 32'd0);
            end else begin
                exp_valid = (held_q.size() != 0);
                exp_rinc  = !flush && !bus.rempty &&
                            ((held_q.size() == 0) || ((held_q.size() == 1) && bus.out_ready));
                check("out_valid", 32'(bus.out_valid), 32'(exp_valid));
                if (exp_valid) begin
                    check("out_data", 32'(bus.out_data), 32'(held_q[0]));
                    check("out_first", 32'(bus.out_first), 32'(held_q.size() == 2));
                end else begin
                    check("idle_data", 32'(bus.out_data), 32'd0);
                    check("idle_first", 32'(bus.out_first), 32'd0);
                end
                check("rinc", 32'(bus.rinc), 32'(exp_rinc));
                check("word_cnt", 32'(word_cnt), 32'(sb_cnt));
                do_fl   = flush;
                do_acc  = exp_valid && bus.out_ready && !flush;
                do_rinc = exp_rinc;
            end
            @(posedge rclk);
            if (rrst_n) begin
                if (do_fl) begin
                    held_q.delete();
                end else begin
                    if (do_acc) begin
                        void'(held_q.pop_front());
                        sb_cnt = sb_cnt + 1'b1;
                    end
                    if (do_rinc) begin
                        held_q.push_back(fifo_q.pop_front());
                        held_q.push_back(fifo_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin : stimulus
        int guard;
        bus.out_ready = 1'b0;
        refresh();
        #12;
        rrst_n = 1'b1;
        #4;
        // Empty FIFO after reset: nothing may move for 10 cycles
        for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 1'b1);

        // Two back-to-back pairs with a ready consumer
        push_pair(8'h11, 8'h22);
        push_pair(8'h33, 8'h44);
        for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, 1'b0);
        check("cnt_after_4", 32'(word_cnt), 32'd4);

        // Same pairs with a 3-cycle stall while 0x22 is presented
        push_pair(8'h11, 8'h22);
        push_pair(8'h33, 8'h44);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check("stall_data", 32'(bus.out_data), 32'h22);
            drive(1'b0, 1'b0, 1'b0);
        end
        drive(1'b1, 1'b0, 1'b0);
        check("after_stall_data", 32'(bus.out_data), 32'h33);
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b0);
        check("cnt_after_8", 32'(word_cnt), 32'd8);

        // Flush while holding a full pair with ready high
        push_pair(8'hA1, 8'hA2);
        push_pair(8'hB1, 8'hB2);
        drive(1'b1, 1'b0, 1'b0);
        check("pre_flush_data", 32'(bus.out_data), 32'hA1);
        drive(1'b1, 1'b1, 1'b0);
        check("flush_valid", 32'(bus.out_valid), 32'd0);
        check("flush_cnt", 32'(word_cnt), 32'd8);
        drive(1'b1, 1'b0, 1'b0);
        check("post_flush_data", 32'(bus.out_data), 32'hB1);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0);

        // Randomised traffic: ready, flush and extra empty stalls
        for (int i = 0; i < 600; i++) begin
            if (fifo_q.size() < 6 && $urandom_range(0, 1) == 1)
                push_pair(DW'($urandom), DW'($urandom));
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
                  $urandom_range(0, 6) == 0);
        end
        drive(1'b0, 1'b1, 1'b1);
        fifo_q.delete();

        // Counter wrap: reset, then deliver 2^CW-2 words, then 3 more
        rrst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b1);
        rrst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b1);
        guard = 0;
        while (sb_cnt != CW'((1 << CW) - 2) && guard < 4000) begin
            if (fifo_q.size() < 4) push_pair(DW'($urandom), DW'($urandom));
            drive(1'b1, 1'b0, 1'b0);
            guard++;
        end
        check("wrap_guard1", 32'(guard < 4000), 32'd1);
        check("cnt_pre_wrap", 32'(word_cnt), 32'((1 << CW) - 2));
        guard = 0;
        while (sb_cnt != CW'(1) && guard < 20) begin
            if (fifo_q.size() < 4) push_pair(DW'($urandom), DW'($urandom));
            drive(1'b1, 1'b0, 1'b0);
            guard++;
        end
        check("wrap_guard2", 32'(guard), 32'd3);
        check("cnt_wrapped", 32'(word_cnt), 32'd1);
        drive(1'b0, 1'b1, 1'b1);
        fifo_q.delete();

        // Asynchronous reset while in HAVE1
        push_pair(8'hC1, 8'hC2);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1);
        check("have1_data", 32'(bus.out_data), 32'hC2);
        bus.out_ready = 1'b0;
        #2;
        rrst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(bus.out_valid), 32'd0);
        check("async_rst_data", 32'(bus.out_data), 32'd0);
        @(posedge rclk);
        #1;
        push_pair(8'hD1, 8'hD2);
        rrst_n = 1'b1;
        drive(1'b1, 1'b0, 1'b0);
        check("post_rst_valid", 32'(bus.out_valid), 32'd1);
        check("post_rst_data", 32'(bus.out_data), 32'hD1);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fifo_rd_pair_unpacker.md
Name: fifo_rd_pair_unpacker

Overview:
- Read-domain drain stage sitting directly downstream of the async FIFO read-pointer/empty logic.
- The read pointer advances by two entries per accepted rinc. This block issues rinc and captures the two addressed words (r_addr and r_addr+1) from the FIFO memory's asynchronous read ports in the same cycle.
- It then serializes the pair as a single-word valid/ready stream to the downstream consumer (e.g. the Display-Port lane packer).
- It also provides a synchronous flush and a delivered-word counter.

Parameters:
- DATA_WIDTH, 8, width of one FIFO word.
- CNT_WIDTH, 16, width of the delivered-word counter.

Ports:
- rclk  input  1  read-domain clock; all state updates on posedge rclk.
- rrst_n  input  1  reset; asynchronous, active-low.
- rempty  input  1  FIFO empty flag; high means fewer than 2 entries available.
- rinc  output  1  pair-read request to pointer logic; combinational.
- rdata_lo  input  DATA_WIDTH  memory word at r_addr (async read).
- rdata_hi  input  DATA_WIDTH  memory word at r_addr+1 (async read).
- flush  input  1  synchronous discard of held words.
- out_data  output  DATA_WIDTH  serialized word.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accept.
- out_first  output  1  high while out_data is the lo word of a pair.
- word_cnt  output  CNT_WIDTH  count of words accepted downstream.

Behaviour:
- Registers:
  - state: IDLE (0 words held), HAVE2, HAVE1.
  - buf_lo, buf_hi (DATA_WIDTH each).
  - word_cnt.
- Reset (async, rrst_n low): state=IDLE, buf_lo=buf_hi=0, word_cnt=0.
  - Hence out_valid=0, out_data=0, out_first=0.
  - rinc=0 whenever state=IDLE and rempty=1, which is the post-reset condition.
- Outputs are decoded from registered state:
  - out_valid = (state!=IDLE).
  - out_data = buf_lo in HAVE2, buf_hi in HAVE1, 0 in IDLE.
  - out_first = (state==HAVE2).
- Accept rule: a word transfers when out_valid && out_ready in the same cycle.
- rinc is combinational and equals !flush && !rempty && (state==IDLE || (state==HAVE1 && out_ready)).
- Capture: whenever rinc=1, buf_lo<=rdata_lo and buf_hi<=rdata_hi on the same edge on which the pointer logic advances. Memory data is sampled before the pointer moves.
- Transitions:
  - IDLE: rinc -> HAVE2; else stay.
  - HAVE2: out_ready -> HAVE1; else hold (buf stable, out_data stable).
  - HAVE1: out_ready && rinc -> HAVE2 (back-to-back, no bubble); out_ready && !rinc -> IDLE; !out_ready -> hold.
- Throughput: sustained 1 word/cycle while rempty=0 and out_ready=1.
- Latency: first out_valid 1 cycle after the first cycle with rempty=0 in IDLE.
- Stability: while out_valid=1 and out_ready=0, out_data and out_first are held constant.
- flush (synchronous, priority over everything except reset):
  - Next state=IDLE; held words discarded.
  - rinc forced 0 that cycle.
  - A word presented in the flush cycle is not counted, even if out_ready=1.
  - word_cnt is not cleared.
- word_cnt increments by 1 per accepted word and wraps modulo 2^CNT_WIDTH (0xFFFF -> 0x0000 at the default width).
- rempty toggling while in HAVE2 has no effect; it is only sampled through rinc.
- Reset asserted mid-pair: remaining buffered word lost; outputs return to reset values immediately, asynchronously.

Test Plan:
- Reset, rempty=1 for 10 cycles -> rinc=0, out_valid=0, word_cnt=0 throughout.
- FIFO holds pairs (0x11,0x22),(0x33,0x44); rempty=0 for exactly two rinc pulses, then 1; out_ready=1 -> out_data sequence 0x11,0x22,0x33,0x44 on 4 consecutive cycles. out_first pattern is 1,0,1,0. rinc pulses occur in the IDLE cycle and the HAVE1 cycle, with no bubble. word_cnt=4.
- Same as the previous scenario with out_ready=0 for 3 cycles while 0x22 is presented -> 0x22 held stable, rinc=0 during the stall. 0x33 follows 1 cycle after out_ready rises.
- flush asserted in HAVE2 with out_ready=1 -> next cycle out_valid=0, word_cnt unchanged, and no rinc in the flush cycle even though rempty=0. The next pair is fetched the following cycle.
- Preload word_cnt to 0xFFFE via 0xFFFE accepted words; deliver 3 more -> word_cnt=0x0001.
- rrst_n dropped asynchronously mid-cycle in HAVE1 -> out_valid=0 and out_data=0 immediately. After release with rempty=0, the first word is valid 1 cycle later.
